// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer
//   Multi-cycle control sequencer for the RISC-V datapath. Steps every
//   instruction through FETCH, DECODE, EXEC, MEM and WB. In each state it
//   issues the PC, instruction register, register file, memory and ALU
//   controls, and it stalls in MEM until the data memory reports ready.
//
// Ports
//   clock            : single clock, rising edge
//   reset            : asynchronous, active-low; clears all state
//   opcode[6:0]      : instruction[6:0], sampled in DECODE
//   zero             : ALU zero flag, steers pcSource for beq in EXEC
//   memReady         : data memory completes the access this cycle (MEM only)
//   pcWrite/pcSource : PC load enable / 0=PC+4, 1=branch target
//   irWrite, rWrite  : instruction register / register file write enables
//   memRead/memWrite : data memory strobes
//   ALUSrc, ALUOp    : ALU operand select / 00 add, 01 sub, 10 funct
//   memoryToRegister : writeback source, 1 = memory
//   halted, busError : in HALT / HALT caused by memory timeout
//   retired[31:0]    : completed instruction count (wraps)
//   state[2:0]       : current state encoding, for debug
module multicycle_sequencer #(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [6:0]  opcode,
   input  logic        zero,
   input  logic        memReady,
   output logic        pcWrite,
   output logic        pcSource,
   output logic        irWrite,
   output logic        rWrite,
   output logic        memRead,
   output logic        memWrite,
   output logic        ALUSrc,
   output logic        memoryToRegister,
   output logic [1:0]  ALUOp,
   output logic        halted,
   output logic        busError,
   output logic [31:0] retired,
   output logic [2:0]  state
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_e;

   typedef enum logic [1:0] {
      C_R   = 2'd0,
      C_LD  = 2'd1,
      C_SD  = 2'd2,
      C_BEQ = 2'd3
   } cls_e;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_SD  = 7'b0100011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   // Last not-ready count before the timeout fires: the edge ending the
   // MEM_TIMEOUT-th not-ready cycle sees the counter at MEM_TIMEOUT-1.
   localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

   state_e      state_q, state_d;
   cls_e        cls_q, cls_d;
   logic [7:0]  wcnt_q, wcnt_d;
   logic        berr_q, berr_d;
   logic [31:0] retired_q;

   // raw (ungated) controls
   logic       pc_wr, pc_src, ir_wr, r_wr, m_rd, m_wr, alu_src, m2r;
   logic [1:0] alu_op;

   always_comb begin
      state_d = state_q;
      cls_d   = cls_q;
      wcnt_d  = wcnt_q;
      berr_d  = berr_q;
      pc_wr   = 1'b0;
      pc_src  = 1'b0;
      ir_wr   = 1'b0;
      r_wr    = 1'b0;
      m_rd    = 1'b0;
      m_wr    = 1'b0;
      alu_src = 1'b0;
      m2r     = 1'b0;
      alu_op  = 2'b00;
      case (state_q)
         S_FETCH: begin
            ir_wr   = 1'b1;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            state_d = S_EXEC;
            case (opcode)
               OP_R:    cls_d = C_R;
               OP_LD:   cls_d = C_LD;
               OP_SD:   cls_d = C_SD;
               OP_BEQ:  cls_d = C_BEQ;
               default: state_d = S_HALT;
            endcase
         end
         S_EXEC: begin
            case (cls_q)
               C_R: begin
                  alu_op  = 2'b10;
                  state_d = S_WB;
               end
               C_LD, C_SD: begin
                  alu_src = 1'b1;
                  wcnt_d  = '0;        // fresh wait budget for this access
                  state_d = S_MEM;
               end
               default: begin         // C_BEQ: resolves and retires here
                  alu_op  = 2'b01;
                  pc_wr   = 1'b1;
                  pc_src  = zero;
                  state_d = S_FETCH;
               end
            endcase
         end
         S_MEM: begin
            alu_src = 1'b1;
            m_rd    = (cls_q == C_LD);
            m_wr    = (cls_q == C_SD);
            if (memReady) begin
               if (cls_q == C_LD) begin
                  state_d = S_WB;
               end else begin
                  pc_wr   = 1'b1;
                  state_d = S_FETCH;
               end
            end else if (wcnt_q == WAIT_LAST) begin
               berr_d  = 1'b1;
               state_d = S_HALT;
            end else begin
               wcnt_d = wcnt_q + 8'd1;
            end
         end
         S_WB: begin
            r_wr  = 1'b1;
            pc_wr = 1'b1;
            if (cls_q == C_R) alu_op = 2'b10;
            else              m2r    = 1'b1;
         end
         S_HALT: ;
         default: state_d = S_HALT;   // unreachable codes 6/7
      endcase
      if (state_q == S_WB) state_d = S_FETCH;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= S_FETCH;
         cls_q     <= C_R;
         wcnt_q    <= '0;
         berr_q    <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q <= state_d;
         cls_q   <= cls_d;
         wcnt_q  <= wcnt_d;
         berr_q  <= berr_d;
         if (pc_wr) retired_q <= retired_q + 32'd1;
      end
   end

   // Strobes are masked by reset so nothing leaks while reset is low,
   // including irWrite in the reset-held FETCH state.
   assign pcWrite          = pc_wr   & reset;
   assign pcSource         = pc_src  & reset;
   assign irWrite          = ir_wr   & reset;
   assign rWrite           = r_wr    & reset;
   assign memRead          = m_rd    & reset;
   assign memWrite         = m_wr    & reset;
   assign ALUSrc           = alu_src & reset;
   assign memoryToRegister = m2r     & reset;
   assign ALUOp            = alu_op  & {2{reset}};
   assign halted           = (state_q == S_HALT);
   assign busError         = berr_q;
   assign retired          = retired_q;
   assign state            = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: one task per scenario, each
// comparing state/strobes per cycle against hand-derived values.
// Strobe vector layout: {pcWrite,pcSource,irWrite,rWrite,memRead,memWrite,
//                        ALUSrc,memoryToRegister,ALUOp[1:0]}
module tb_multicycle_sequencer;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [6:0]  opcode = 7'b0110011;
   logic        zero = 1'b0;
   logic        memReady = 1'b0;
   logic        pcWrite, pcSource, irWrite, rWrite, memRead, memWrite;
   logic        ALUSrc, memoryToRegister, halted, busError;
   logic [1:0]  ALUOp;
   logic [31:0] retired;
   logic [2:0]  state;
   int          checks = 0;
   int          errors = 0;

   multicycle_sequencer #(.MEM_TIMEOUT(15)) dut (
      .clock(clock), .reset(reset), .opcode(opcode), .zero(zero),
      .memReady(memReady), .pcWrite(pcWrite), .pcSource(pcSource),
      .irWrite(irWrite), .rWrite(rWrite), .memRead(memRead),
      .memWrite(memWrite), .ALUSrc(ALUSrc),
      .memoryToRegister(memoryToRegister), .ALUOp(ALUOp), .halted(halted),
      .busError(busError), .retired(retired), .state(state)
   );

   always #5 clock = ~clock;

   logic [9:0] strobes;
   assign strobes = {pcWrite, pcSource, irWrite, rWrite, memRead, memWrite,
                     ALUSrc, memoryToRegister, ALUOp};

   // Reset pulse; returns 1ns into the first FETCH cycle.
   task automatic do_reset();
      reset = 1'b0;
      memReady = 1'b0;
      zero = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      #1;
   endtask

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #1 reset = 1'b0;
      #1;
      checks++;
      if (state !== 3'd0 || retired !== 32'd0 || halted !== 1'b0 || busError !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: state=%0d retired=%0d halted=%b busError=%b, want 0 0 0 0",
                  state, retired, halted, busError);
      end
      @(posedge clock); #1;
      checks++;
      if (strobes !== 10'h000 || state !== 3'd0) begin
         errors++;
         $display("FAIL reset_strobes: state=%0d strobes=%h, want 0 000", state, strobes);
      end
   endtask

   task automatic test_r_type();
      logic [2:0] st [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
      logic [9:0] sb [5] = '{10'h080, 10'h000, 10'h002, 10'h242, 10'h080};
      do_reset();
      opcode = 7'b0110011;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (state !== st[i] || strobes !== sb[i]) begin
            errors++;
            $display("FAIL r_type cyc%0d: state=%0d strobes=%h, want %0d %h",
                     i, state, strobes, st[i], sb[i]);
         end
         if (i == 3) begin
            checks++;
            if (retired !== 32'd0) begin
               errors++;
               $display("FAIL r_type_pre_retire: retired=%0d, want 0", retired);
            end
         end
         if (i < 4) next_cycle();
      end
      checks++;
      if (retired !== 32'd1) begin
         errors++;
         $display("FAIL r_type_retired: retired=%0d, want 1", retired);
      end
   endtask

   // memReady is also driven high outside MEM to show it is ignored there.
   task automatic test_ld_wait();
      logic [2:0] st [9] = '{0, 1, 2, 3, 3, 3, 3, 4, 0};
      logic [9:0] sb [9] = '{10'h080, 10'h000, 10'h008, 10'h028, 10'h028,
                             10'h028, 10'h028, 10'h244, 10'h080};
      logic       rdy [9] = '{1, 1, 1, 0, 0, 0, 1, 1, 0};
      do_reset();
      opcode = 7'b0000011;
      for (int i = 0; i < 9; i++) begin
         memReady = rdy[i];
         #1;
         checks++;
         if (state !== st[i] || strobes !== sb[i]) begin
            errors++;
            $display("FAIL ld_wait cyc%0d: state=%0d strobes=%h, want %0d %h",
                     i, state, strobes, st[i], sb[i]);
         end
         if (i < 8) next_cycle();
      end
      checks++;
      if (retired !== 32'd1 || busError !== 1'b0) begin
         errors++;
         $display("FAIL ld_wait_retired: retired=%0d busError=%b, want 1 0", retired, busError);
      end
   endtask

   task automatic test_beq();
      logic [2:0] st [7] = '{0, 1, 2, 0, 1, 2, 0};
      logic [9:0] sb [7] = '{10'h080, 10'h000, 10'h301, 10'h080, 10'h000,
                             10'h201, 10'h080};
      logic       z  [7] = '{1, 1, 1, 0, 0, 0, 0};
      do_reset();
      opcode = 7'b1100011;
      for (int i = 0; i < 7; i++) begin
         zero = z[i];
         #1;
         checks++;
         if (state !== st[i] || strobes !== sb[i]) begin
            errors++;
            $display("FAIL beq cyc%0d: state=%0d strobes=%h, want %0d %h",
                     i, state, strobes, st[i], sb[i]);
         end
         if (i == 3) begin
            checks++;
            if (retired !== 32'd1) begin
               errors++;
               $display("FAIL beq_retired1: retired=%0d, want 1", retired);
            end
         end
         if (i < 6) next_cycle();
      end
      checks++;
      if (retired !== 32'd2) begin
         errors++;
         $display("FAIL beq_retired2: retired=%0d, want 2", retired);
      end
   endtask

   // Ready arrives in the 15th MEM cycle: completes normally, no error.
   task automatic test_sd_boundary();
      logic [2:0] exp_st;
      logic [9:0] exp_sb;
      do_reset();
      opcode = 7'b0100011;
      for (int i = 0; i < 19; i++) begin
         memReady = (i == 17);
         #1;
         exp_st = (i < 3) ? 3'(i) : (i < 18) ? 3'd3 : 3'd0;
         exp_sb = (i == 0) ? 10'h080 : (i == 1) ? 10'h000 : (i == 2) ? 10'h008 :
                  (i == 17) ? 10'h218 : (i == 18) ? 10'h080 : 10'h018;
         checks++;
         if (state !== exp_st || strobes !== exp_sb) begin
            errors++;
            $display("FAIL sd_boundary cyc%0d: state=%0d strobes=%h, want %0d %h",
                     i, state, strobes, exp_st, exp_sb);
         end
         if (i < 18) next_cycle();
      end
      checks++;
      if (retired !== 32'd1 || busError !== 1'b0 || halted !== 1'b0) begin
         errors++;
         $display("FAIL sd_boundary_end: retired=%0d busError=%b halted=%b, want 1 0 0",
                  retired, busError, halted);
      end
   endtask

   task automatic test_sd_timeout();
      logic [2:0] exp_st;
      logic [9:0] exp_sb;
      do_reset();
      opcode = 7'b0100011;
      memReady = 1'b0;
      for (int i = 0; i < 21; i++) begin
         exp_st = (i < 3) ? 3'(i) : (i < 18) ? 3'd3 : 3'd5;
         exp_sb = (i == 0) ? 10'h080 : (i == 1) ? 10'h000 : (i == 2) ? 10'h008 :
                  (i < 18) ? 10'h018 : 10'h000;
         checks++;
         if (state !== exp_st || strobes !== exp_sb) begin
            errors++;
            $display("FAIL sd_timeout cyc%0d: state=%0d strobes=%h, want %0d %h",
                     i, state, strobes, exp_st, exp_sb);
         end
         if (i < 20) next_cycle();
      end
      checks++;
      if (halted !== 1'b1 || busError !== 1'b1 || retired !== 32'd0) begin
         errors++;
         $display("FAIL sd_timeout_halt: halted=%b busError=%b retired=%0d, want 1 1 0",
                  halted, busError, retired);
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      opcode = 7'b0000011;
      memReady = 1'b0;
      repeat (3) next_cycle();
      checks++;
      if (state !== 3'd3 || memRead !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset_pre: state=%0d memRead=%b, want 3 1", state, memRead);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (state !== 3'd0 || strobes !== 10'h000 || retired !== 32'd0) begin
         errors++;
         $display("FAIL mid_reset_abort: state=%0d strobes=%h retired=%0d, want 0 000 0",
                  state, strobes, retired);
      end
      memReady = 1'b1;
      next_cycle();
      checks++;
      if (state !== 3'd0 || strobes !== 10'h000 || retired !== 32'd0) begin
         errors++;
         $display("FAIL mid_reset_hold: state=%0d strobes=%h retired=%0d, want 0 000 0",
                  state, strobes, retired);
      end
      reset = 1'b1;
   endtask

   task automatic test_illegal();
      logic [2:0] st [3] = '{0, 1, 5};
      logic [9:0] sb [3] = '{10'h080, 10'h000, 10'h000};
      do_reset();
      opcode = 7'b1111111;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (state !== st[i] || strobes !== sb[i]) begin
            errors++;
            $display("FAIL illegal cyc%0d: state=%0d strobes=%h, want %0d %h",
                     i, state, strobes, st[i], sb[i]);
         end
         if (i < 2) next_cycle();
      end
      opcode = 7'b0110011;
      memReady = 1'b1;
      repeat (4) next_cycle();
      checks++;
      if (state !== 3'd5 || halted !== 1'b1 || busError !== 1'b0 ||
          strobes !== 10'h000 || retired !== 32'd0) begin
         errors++;
         $display("FAIL illegal_hold: state=%0d halted=%b busError=%b strobes=%h retired=%0d, want 5 1 0 000 0",
                  state, halted, busError, strobes, retired);
      end
      do_reset();
      checks++;
      if (state !== 3'd0 || halted !== 1'b0 || irWrite !== 1'b1 || retired !== 32'd0) begin
         errors++;
         $display("FAIL illegal_resume: state=%0d halted=%b irWrite=%b retired=%0d, want 0 0 1 0",
                  state, halted, irWrite, retired);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      opcode = 7'b1100011;
      zero = 1'b0;
      next_cycle();                     // DECODE: no retire this edge
      force dut.retired_q = 32'hFFFF_FFFF;
      #1;
      release dut.retired_q;
      #1;
      checks++;
      if (retired !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL wrap_preload: retired=%h, want ffffffff", retired);
      end
      next_cycle();                     // EXEC, retiring
      checks++;
      if (state !== 3'd2 || pcWrite !== 1'b1 || retired !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL wrap_exec: state=%0d pcWrite=%b retired=%h, want 2 1 ffffffff",
                  state, pcWrite, retired);
      end
      next_cycle();
      checks++;
      if (retired !== 32'd0 || state !== 3'd0) begin
         errors++;
         $display("FAIL wrap_result: retired=%h state=%0d, want 00000000 0", retired, state);
      end
   endtask

   initial begin
      test_reset();
      test_r_type();
      test_ld_wait();
      test_beq();
      test_sd_boundary();
      test_sd_timeout();
      test_mid_reset();
      test_illegal();
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog expired");
   end
endmodule
